// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: types and constants shared by the async FIFO read-side logic
package async_fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int RD_LATENCY = 1;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry ordered buffer, entry 0 is the head; a capture lands in the first free slot after a pop shift
module rd_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);
    occ_e state, state_nxt;
    logic [DATA_WIDTH-1:0] ent0, ent1, ent0_nxt, ent1_nxt;
    logic [1:0] occ_sum, after_pop;
    logic wr_head;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            state <= state_nxt;
            ent0 <= ent0_nxt;
            ent1 <= ent1_nxt;
        end
    end
    always_comb begin
        occ_sum = state + {1'b0, push} - {1'b0, pop};
        state_nxt = occ_e'(occ_sum);
        after_pop = state - {1'b0, pop};
        wr_head = after_pop == 2'd0;
        ent0_nxt = (push && wr_head) ? din : pop ? ent1 : ent0;
        ent1_nxt = (push && !wr_head) ? din : ent1;
    end
    assign occ = state;
    assign head = ent0;
    // The issue rule upstream must keep occupancy within EMPTY..TWO
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && state == OCC_EMPTY));
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && state == OCC_TWO));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops the async FIFO and presents its words as a valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to add the saturating beat_cnt output.
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           beat_cnt
`endif
);
    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("fifo_rd_stream: BUF_DEPTH must be 2");
    end
    if (RD_LATENCY != 1) begin : g_bad_latency
        $error("fifo_rd_stream: only a 1-cycle FIFO read latency is supported");
    end
    logic inflight, beat;
    logic [1:0] occ;
    logic [2:0] pending;
    assign m_valid = occ != 2'd0;
    assign beat = m_valid & m_ready;
    assign pending = {1'b0, occ} + {2'b0, inflight};
    // A slot freed by this cycle's beat can take a word issued now
    assign fifo_r_en = rrst_n & ~fifo_empty & ((pending < 3'(BUF_DEPTH)) | beat);
    always_ff @(posedge r_clk) begin
        if (!rrst_n) inflight <= 1'b0;
        else inflight <= fifo_r_en;
    end
    rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk   (r_clk),
        .rst_n (rrst_n),
        .push  (inflight),
        .din   (fifo_rdata),
        .pop   (beat),
        .occ   (occ),
        .head  (m_data)
    );
`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge r_clk) begin
        if (!rrst_n) beat_cnt <= '0;
        else beat_cnt <= (beat && beat_cnt != 16'hFFFF) ? beat_cnt + 16'd1 : beat_cnt;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream against a 1-cycle-latency FIFO model
module tb_fifo_rd_stream;
    logic r_clk = 1'b0;
    logic rrst_n = 1'b0;
    logic fifo_empty, fifo_r_en, m_valid;
    logic m_ready = 1'b0;
    logic [7:0] fifo_rdata = 8'h00;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] beat_cnt;
`endif
    logic [7:0] mem [1024];
    logic [7:0] rx [1024];
    int wp = 0, rp = 0, rx_n = 0;
    int errors = 0, checks = 0;

    always #5 r_clk = ~r_clk;
    assign fifo_empty = (wp == rp);

    fifo_rd_stream dut (
        .r_clk      (r_clk),
        .rrst_n     (rrst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    always @(posedge r_clk) begin
        if (!rrst_n) rp <= wp;
        else if (fifo_r_en && wp != rp) begin
            fifo_rdata <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    always @(posedge r_clk)
        if (rrst_n && m_valid && m_ready) begin
            rx[rx_n % 1024] <= m_data;
            rx_n <= rx_n + 1;
        end

    task automatic push_word(input logic [7:0] w);
        mem[wp % 1024] = w;
        wp = wp + 1;
    endtask

    task automatic apply_reset();
        rrst_n = 1'b0;
        m_ready = 1'b0;
        @(negedge r_clk);
        @(negedge r_clk);
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        m_ready = 1'b1;
        @(negedge r_clk);
        push_word(8'hAA);
        #1;
        checks++;
        if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b expected 0", fifo_r_en); end
        @(negedge r_clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        rrst_n = 1'b1;
        m_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic exp_en, exp_v;
        logic [7:0] exp_d;
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(8'h11 + i));
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge r_clk); #1; end
            exp_en = k < 5;
            exp_v = k >= 2 && k <= 6;
            exp_d = 8'(8'h11 + k - 2);
            checks++;
            if (fifo_r_en !== exp_en) begin errors++; $display("FAIL stream_r_en[%0d]: got %b expected %b", k, fifo_r_en, exp_en); end
            checks++;
            if (m_valid !== exp_v) begin errors++; $display("FAIL stream_m_valid[%0d]: got %b expected %b", k, m_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (m_data !== exp_d) begin errors++; $display("FAIL stream_m_data[%0d]: got %h expected %h", k, m_data, exp_d); end
            end
        end
    endtask

    task automatic test_backpressure();
        int pops, start;
        logic [7:0] exp_d;
        apply_reset();
        for (int i = 0; i < 3; i++) push_word(8'(8'h11 + i));
        #1;
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge r_clk); #1; end
            if (fifo_r_en) pops++;
        end
        checks++;
        if (pops !== 2) begin errors++; $display("FAIL bp_pops: got %0d expected 2", pops); end
        checks++;
        if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL bp_r_en_full: got %b expected 0", fifo_r_en); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=11", m_valid, m_data); end
        start = rx_n;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && rx_n - start < 3; k++) @(negedge r_clk);
        repeat (3) @(negedge r_clk);
        checks++;
        if (rx_n - start !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", rx_n - start); end
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'(8'h11 + i);
            checks++;
            if (rx[(start + i) % 1024] !== exp_d) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, rx[(start + i) % 1024], exp_d); end
        end
    endtask

    task automatic test_random();
        int start, viol, bad;
        logic hold;
        logic [7:0] hold_d;
        apply_reset();
        start = rx_n;
        for (int i = 0; i < 200; i++) push_word(8'(i * 37 + 5));
        hold = 1'b0;
        hold_d = 8'h00;
        viol = 0;
        for (int c = 0; c < 3000 && rx_n - start < 200; c++) begin
            @(negedge r_clk);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold && (m_valid !== 1'b1 || m_data !== hold_d)) viol++;
            hold = m_valid & ~m_ready;
            hold_d = m_data;
        end
        m_ready = 1'b0;
        repeat (3) @(negedge r_clk);
        checks++;
        if (rx_n - start !== 200) begin errors++; $display("FAIL rand_count: got %0d expected 200", rx_n - start); end
        bad = 0;
        for (int i = 0; i < 200; i++) if (rx[(start + i) % 1024] !== 8'(i * 37 + 5)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rand_order: got %0d wrong words expected 0", bad); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL rand_stable: got %0d unstable cycles expected 0", viol); end
    endtask

    task automatic test_empty();
        int en_seen, v_seen;
        apply_reset();
        en_seen = 0;
        v_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge r_clk);
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (fifo_r_en !== 1'b0) en_seen++;
            if (m_valid !== 1'b0) v_seen++;
        end
        checks++;
        if (en_seen !== 0) begin errors++; $display("FAIL empty_r_en: got %0d pops expected 0", en_seen); end
        checks++;
        if (v_seen !== 0) begin errors++; $display("FAIL empty_m_valid: got %0d valid cycles expected 0", v_seen); end
    endtask

    task automatic test_reset_midstream();
        int start;
        apply_reset();
        start = rx_n;
        for (int i = 0; i < 3; i++) push_word(8'(8'h31 + i));
        @(negedge r_clk);
        @(negedge r_clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h31) begin errors++; $display("FAIL mid_pre: got v=%b d=%h expected v=1 d=31", m_valid, m_data); end
        rrst_n = 1'b0;
        @(negedge r_clk);
        rrst_n = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_data !== 8'h00) begin errors++; $display("FAIL mid_m_data: got %h expected 00", m_data); end
        checks++;
        if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL mid_r_en: got %b expected 0", fifo_r_en); end
        @(negedge r_clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got v=%b d=%h expected v=0", m_valid, m_data); end
        push_word(8'h41);
        m_ready = 1'b1;
        @(negedge r_clk);
        @(negedge r_clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h41) begin errors++; $display("FAIL mid_restart: got v=%b d=%h expected v=1 d=41", m_valid, m_data); end
        @(negedge r_clk);
        m_ready = 1'b0;
        checks++;
        if (rx_n - start !== 1) begin errors++; $display("FAIL mid_delivered: got %0d expected 1", rx_n - start); end
    endtask

`ifdef FIFO_RD_STREAM_CNT_EN
    task automatic test_beat_cnt();
        int start;
        apply_reset();
        #1;
        checks++;
        if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_reset: got %h expected 0000", beat_cnt); end
        start = rx_n;
        m_ready = 1'b1;
        for (int c = 0; c < 80000 && rx_n - start < 70000; c++) begin
            @(negedge r_clk);
            if (wp - rp < 4) push_word(8'(c));
        end
        m_ready = 1'b0;
        @(negedge r_clk);
        #1;
        checks++;
        if (beat_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h expected ffff", beat_cnt); end
        rrst_n = 1'b0;
        @(negedge r_clk);
        rrst_n = 1'b1;
        #1;
        checks++;
        if (beat_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_clear: got %h expected 0000", beat_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_empty();
        test_reset_midstream();
`ifdef FIFO_RD_STREAM_CNT_EN
        test_beat_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
